// File: rtl/divider_pkg.sv
// Shared constants for the shift-subtract divider.
// The defaults match the shift-add multiplier it inverts.
package divider_pkg;

    localparam int DIV_N = 8;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DIV_N);

    // Quotient image loaded when an operation cannot produce a real result.
    localparam logic [DIV_N-1:0] ERR_QUOT = '1;

endpackage

// File: rtl/divider2_step.sv
// One restoring-division trial subtract on the partial remainder.
// Produces the next upper half of R and the quotient bit that shifts into the lower half.
module divider2_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] rem_i,
    input  logic         msb_i,
    input  logic [N-1:0] bb_i,
    output logic [N-1:0] rem_o,
    output logic         qbit_o
);

    logic [N:0] trial;
    logic [N:0] diff;

    // The upper half is always below BB, so trial - BB never needs more than N+1 bits.
    always_comb begin
        trial  = {rem_i, msb_i};
        diff   = trial - {1'b0, bb_i};
        qbit_o = ~diff[N];
        rem_o  = qbit_o ? diff[N-1:0] : trial[N-1:0];
    end

endmodule

// File: rtl/divider2.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor in N cycles.
// Divide-by-zero and quotient overflow are flagged and finish after a single step.
module divider2
    import divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] A,
    input  logic [N-1:0]   B,
    output logic [N-1:0]   Quotient,
    output logic [N-1:0]   Remainder,
    output logic           ready,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_DONE = CW'(N);
    localparam logic [N-1:0]  ERR_Q    = '1;

    logic [2*N-1:0] r_q, r_d;
    logic [N-1:0]   bb_q, bb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dz_q, dz_d;
    logic           ov_q, ov_d;
    logic [N-1:0]   rem_next;
    logic           qbit;

    divider2_step #(.N(N)) u_step (
        .rem_i  (r_q[2*N-1:N]),
        .msb_i  (r_q[N-1]),
        .bb_i   (bb_q),
        .rem_o  (rem_next),
        .qbit_o (qbit)
    );

    always_comb begin
        r_d   = r_q;
        bb_d  = bb_q;
        cnt_d = cnt_q;
        dz_d  = dz_q;
        ov_d  = ov_q;
        if (start) begin
            if (B == '0) begin
                dz_d  = 1'b1;
                ov_d  = 1'b0;
                r_d   = {{N{1'b0}}, ERR_Q};
                cnt_d = CNT_DONE - 1'b1;
            end else if (A[2*N-1:N] >= B) begin
                dz_d  = 1'b0;
                ov_d  = 1'b1;
                r_d   = {{N{1'b0}}, ERR_Q};
                cnt_d = CNT_DONE - 1'b1;
            end else begin
                dz_d  = 1'b0;
                ov_d  = 1'b0;
                r_d   = A;
                bb_d  = B;
                cnt_d = '0;
            end
        end else if (cnt_q != CNT_DONE) begin
            // Error loads keep their all-ones image; only the counter walks to done.
            if (!(dz_q || ov_q)) begin
                r_d = {rem_next, r_q[N-2:0], qbit};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            bb_q  <= '0;
            cnt_q <= CNT_DONE;
            dz_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            r_q   <= r_d;
            bb_q  <= bb_d;
            cnt_q <= cnt_d;
            dz_q  <= dz_d;
            ov_q  <= ov_d;
        end
    end

    assign Quotient    = r_q[N-1:0];
    assign Remainder   = r_q[2*N-1:N];
    assign ready       = (cnt_q == CNT_DONE);
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_divider2.sv
// Self-checking bench for divider2 against an arithmetic reference (A/B, A%B).
module tb_divider2;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2*N-1:0] A = '0;
    logic [N-1:0]   B = '0;
    logic [N-1:0]   Quotient, Remainder;
    logic           ready, div_by_zero, overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    divider2 #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference: what a correct divider must return for the given operands.
    function automatic void ref_div(input logic [2*N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic dz, output logic ov, output int lat);
        int unsigned ai, bi;
        ai = a;
        bi = b;
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            dz = 1'b1; q = '1; r = '0; lat = 1;
        end else if (ai / bi > 255) begin
            ov = 1'b1; q = '1; r = '0; lat = 1;
        end else begin
            q = N'(ai / bi); r = N'(ai % bi); lat = N;
        end
    endfunction

    // Pulse start for one edge, then count cycles until ready (bounded).
    task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [2*N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] eq, er;
        logic edz, eov;
        int elat, lat;
        ref_div(a, b, eq, er, edz, eov, elat);
        run_op(a, b, lat);
        n_cmp++;
        if (lat != elat) begin
            n_fail++;
            $display("FAIL %s latency A=%h B=%h: got %0d cycles, need %0d", name, a, b, lat, elat);
        end
        n_cmp++;
        if (Quotient !== eq) begin
            n_fail++;
            $display("FAIL %s quotient A=%h B=%h: got %h, need %h", name, a, b, Quotient, eq);
        end
        n_cmp++;
        if (Remainder !== er) begin
            n_fail++;
            $display("FAIL %s remainder A=%h B=%h: got %h, need %h", name, a, b, Remainder, er);
        end
        n_cmp++;
        if (div_by_zero !== edz) begin
            n_fail++;
            $display("FAIL %s div_by_zero A=%h B=%h: got %b, need %b", name, a, b, div_by_zero, edz);
        end
        n_cmp++;
        if (overflow !== eov) begin
            n_fail++;
            $display("FAIL %s overflow A=%h B=%h: got %b, need %b", name, a, b, overflow, eov);
        end
    endtask

    task automatic test_reset;
        logic [4*N+3-1:0] got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got = {Quotient, Remainder, ready, div_by_zero, overflow, 16'h0};
        n_cmp++;
        if (got[4*N+2:16] !== {8'h00, 8'h00, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_state: got Q=%h R=%h rdy=%b dz=%b ov=%b, need 00 00 1 0 0",
                     Quotient, Remainder, ready, div_by_zero, overflow);
        end
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        start = 1'b1; A = 16'd1000; B = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({Quotient, Remainder, ready, div_by_zero, overflow} !== {8'h00, 8'h00, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_mid_op_immediate: got Q=%h R=%h rdy=%b dz=%b ov=%b, need 00 00 1 0 0",
                     Quotient, Remainder, ready, div_by_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({Quotient, Remainder, ready, div_by_zero, overflow} !== {8'h00, 8'h00, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_mid_op_release: got Q=%h R=%h rdy=%b dz=%b ov=%b, need 00 00 1 0 0",
                     Quotient, Remainder, ready, div_by_zero, overflow);
        end
    endtask

    task automatic test_normal_hold;
        check_op("normal", 16'd1000, 8'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({Quotient, Remainder, ready} !== {8'd142, 8'd6, 1'b1}) begin
                n_fail++;
                $display("FAIL hold_idle cycle %0d: got Q=%0d R=%0d rdy=%b, need 142 6 1",
                         i, Quotient, Remainder, ready);
            end
        end
    endtask

    task automatic test_boundaries;
        check_op("max_valid", 16'hFEFF, 8'hFF);
        check_op("overflow", 16'h0100, 8'h01);
        check_op("div_zero", 16'h1234, 8'h00);
        check_op("after_dz", 16'h0042, 8'h05);
        check_op("ov_equal", 16'h0700, 8'h07);
        check_op("zero_div", 16'h0000, 8'h01);
    endtask

    task automatic test_restart_busy;
        @(negedge clk);
        start = 1'b1; A = 16'd1000; B = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_op("restart_busy", 16'd255, 8'd16);
    endtask

    task automatic test_start_held;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = 16'(i * 300 + 77); B = 8'(i + 9);
            @(negedge clk);
            n_cmp++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL start_held_ready step %0d: got %b, need 0", i, ready);
            end
        end
        start = 1'b0;
        check_op("start_held_last", 16'd2000, 8'd13);
    endtask

    task automatic test_random;
        logic [2*N-1:0] a;
        logic [N-1:0] b;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: begin b = '0; a = 16'($urandom); end
                1: begin
                    b = 8'($urandom_range(1, 255));
                    a = {8'($urandom_range(b, 255)), 8'($urandom)};
                end
                default: begin
                    b = 8'($urandom_range(1, 255));
                    a = {8'($urandom_range(0, b - 1)), 8'($urandom)};
                end
            endcase
            check_op("random", a, b);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_normal_hold();
        test_boundaries();
        test_restart_busy();
        test_start_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/divider2.md
# divider2

Sequential restoring shift-subtract divider. It divides a 2N-bit unsigned dividend by an N-bit unsigned divisor, producing an N-bit quotient and an N-bit remainder in N cycles. It is the inverse datapath of the team's shift-add multiplier: the same start/ready handshake, the same single shared Product-style shift register, and N = 8 by default, so a 16-bit product divided by one 8-bit factor recovers the other. Division by zero and quotient overflow are flagged and complete in one cycle.

## Interface
- N, 8, operand width; dividend is 2N bits; quotient, remainder and divisor are N bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load operands and begin; sampled every edge, has priority over everything
- A  in  2N  unsigned dividend
- B  in  N  unsigned divisor
- Quotient  out  N  result, valid while ready=1
- Remainder  out  N  result, valid while ready=1
- ready  out  1  high when idle/done (counter == N)
- div_by_zero  out  1  last accepted B was 0
- overflow  out  1  last accepted A[2N-1:N] >= B, with B != 0 (quotient does not fit in N bits)

## Operation
- State: 2N-bit register R (upper half = partial remainder, lower half = dividend bits / quotient bits), N-bit BB, counter of width $clog2(N)+1, two flag registers.
- Quotient = R[N-1:0] and Remainder = R[2N-1:N], both driven continuously; ready = (counter == N).
- Load (start=1 at an edge):
  - B == 0: div_by_zero<=1, overflow<=0, R<={N'b0, {N{1'b1}}}, counter<=N-1.
  - else if A[2N-1:N] >= B: overflow<=1, div_by_zero<=0, R<={N'b0, {N{1'b1}}}, counter<=N-1.
  - else: flags<=0, R<=A, BB<=B, counter<=0.
- Iterate (start=0, ready=0): the trial value T = {R[2N-1:N], R[N-1]} is N+1 bits; D = T - {1'b0, BB}.
  - If D is non-negative, the upper half becomes D[N-1:0] and quotient bit 1 is shifted in.
  - Otherwise the upper half becomes T[N-1:0] and quotient bit 0 is shifted in.
  - In both cases R[N-1:0] <= {R[N-2:0], qbit}, and counter <= counter+1.
  - On error paths the R image is held during the single step; only the counter advances.
- Done (ready=1, start=0): all registers hold; results are stable indefinitely.
- Invariant: the upper half stays < BB, so D always fits in N bits; no carry-out is lost.

## Timing
- Reset (async, rst_n=0): R=0, BB=0, counter=N, flags=0. Hence Quotient=0, Remainder=0, ready=1, div_by_zero=0, overflow=0. Release is synchronous to the next clk edge.
- Normal latency:
  - start is sampled at edge k; ready falls after edge k.
  - Iterations occur at edges k+1..k+N.
  - ready rises after edge k+N with the results valid in the same cycle.
- Error latency: ready is low for exactly one cycle; results and flag are valid after edge k+1.
- Flags update only on load; they stay valid alongside the result until the next start.
- start asserted while busy aborts the current operation and reloads with the new operands; no partial result is exposed as valid.
- start held high reloads every edge; ready stays 0 (counter=0) or toggles per the error path, and iteration begins on the first edge with start=0.
- rst_n asserted mid-operation returns immediately to reset values; no result from that operation.

## Structure
- Shared package divider_pkg:
  - DIV_N default (8).
  - CNT_W = $clog2(N)+1.
  - The all-ones error quotient constant.
- One sub-module, divider2_step: combinational trial subtract.
  - Inputs: R, BB.
  - Outputs: next R image and qbit.
  - Keeps the top level to the control path (counter, load, flags).

## Test plan
- Reset mid-operation: start A=16'd1000, B=8'd7; pull rst_n low at cycle 3 -> Quotient=0, Remainder=0, ready=1, flags=0 immediately and after release.
- Normal: A=16'd1000, B=8'd7 -> ready low for 8 cycles, then Quotient=142, Remainder=6, flags=0; values hold for 5 idle cycles.
- Max valid: A=16'hFEFF, B=8'hFF -> Quotient=8'hFF, Remainder=8'hFE after 8 cycles, overflow=0.
- Overflow: A=16'h0100, B=8'h01 -> overflow=1, Quotient=8'hFF, Remainder=0, ready after 1 cycle.
- Divide by zero: A=16'h1234, B=0 -> div_by_zero=1, overflow=0, Quotient=8'hFF, Remainder=0, ready after 1 cycle; the next valid start clears the flag.
- Restart while busy: start A=16'd1000, B=7; re-start at cycle 4 with A=16'd255, B=16 -> 8 cycles after the second start, Quotient=15, Remainder=15.
